gol_sequencer: RTL
==================

# gol_sequencer

Generation controller for the Game of Life display path. It decodes the four board keys (run/pause, single-step, clear, speed) and schedules each generation sweep of the next-state engine over the cell grid. It swaps the double-buffered grid only at vertical blank, so the VGA scan never shows a half-updated frame. It sits between the key inputs, the VGA timing generator and the `game_of_life` cell engine.

## Interface
Parameters:
- `COLS`, 32: grid width in cells.
- `ROWS`, 24: grid height in cells.
- `XW`, 5: width of `sweep_x` (≥ clog2(COLS)).
- `YW`, 5: width of `sweep_y` (≥ clog2(ROWS)).

Ports:
- `clk`, in, 1: system clock (single clock domain).
- `reset`, in, 1: synchronous, active-high.
- `Key`, in, 4: raw board keys, active-low, asynchronous. Bit 0 run/pause, bit 1 step, bit 2 clear, bit 3 speed.
- `vblank_start`, in, 1: one-cycle pulse from VGA timing at the first vertical-blank line.
- `sweep_valid`, out, 1: the current sweep coordinate is valid.
- `sweep_ready`, in, 1: engine accepts a coordinate. A transfer occurs when `sweep_valid && sweep_ready`.
- `sweep_x`, out, XW: column of the current cell.
- `sweep_y`, out, YW: row of the current cell.
- `sweep_clr`, out, 1: engine writes 0 to the cell instead of the next state. Constant for a whole sweep.
- `eng_idle`, in, 1: engine pipeline is empty.
- `buf_sel`, out, 1: front (display) buffer index. The engine writes buffer `~buf_sel`.
- `running`, out, 1: free-run mode active.
- `speed`, out, 2: speed index.
- `gen_count`, out, 16: number of completed generations.

## Operation
- Key input handling:
  - 2-FF synchronizer per key, then falling-edge detect.
  - The result is a one-cycle event per press. Debounce is external.
- Key event decisions:
  - Run (bit 0): toggles `running`. Accepted in any state.
  - Speed (bit 3): `speed` increments mod 4 and takes effect at the next frame count.
  - Frames per generation = 8 >> `speed`, giving 8, 4, 2, 1.
  - Clear (bit 2): sets `clr_pend`.
  - Step (bit 1): sets `step_pend` only while `running` = 0.
  - Clear and step in the same cycle: clear wins and the step is dropped.
- FSM states: IDLE, SWEEP, DRAIN, SWAP.
- IDLE:
  - `clr_pend` → SWEEP with `sweep_clr` = 1. `clr_pend` is cleared on entry.
  - Else if `step_pend` → SWEEP with `sweep_clr` = 0. `step_pend` is cleared on entry.
  - Else if `running`, on `vblank_start`: `frame_cnt` increments. When `frame_cnt` reaches (8 >> `speed`) − 1, it resets to 0 and the FSM goes to SWEEP.
- SWEEP:
  - Raster order: x = 0..COLS−1 inner loop, y = 0..ROWS−1 outer loop.
  - Coordinates advance only on a transfer. `sweep_valid` stays high and the coordinates stay stable while `sweep_ready` is low.
  - The transfer at (COLS−1, ROWS−1) → DRAIN, with `sweep_valid` deasserted the next cycle.
- DRAIN: wait for `eng_idle` = 1, then → SWAP.
- SWAP:
  - Wait for `vblank_start`. In that same cycle: toggle `buf_sel`, then → IDLE.
  - Update `gen_count`: +1 mod 2^16 for a normal sweep, 0 for a clear sweep.
  - A `vblank_start` consumed by SWAP does not advance `frame_cnt`.
- Key events arriving during SWEEP, DRAIN or SWAP only set pend flags or toggle `running`. A sweep in progress is never aborted.
- Pausing mid-sweep lets the current generation complete and swap.
- Reset mid-sweep: all state returns to reset values on the next edge. `sweep_valid` drops immediately and the half-written back buffer is discarded, because `buf_sel` = 0 remains the front buffer.

## Timing
- Reset values:
  - `sweep_valid` = 0, `sweep_x` = `sweep_y` = 0, `sweep_clr` = 0.
  - `buf_sel` = 0, `running` = 0, `speed` = 0, `gen_count` = 0.
  - `frame_cnt` = 0, pend flags = 0, state IDLE.
- Key latency: press edge on `Key` to event = 3 clk (2 sync + 1 edge register). `running` and `speed` change on the following edge.
- IDLE → SWEEP: `sweep_valid` rises 1 cycle after the triggering event or `vblank_start`.
- Sweep length: exactly COLS×ROWS transfers. With `sweep_ready` held high this is 768 cycles at the defaults.
- All outputs are registered. `sweep_clr` is stable from the first beat to the last.
- `buf_sel` toggles only in a cycle where `vblank_start` = 1.

## Structure
- Shared package `gol_pkg` holds:
  - the FSM state enum (IDLE/SWEEP/DRAIN/SWAP);
  - key bit indices `KEY_RUN` = 0, `KEY_STEP` = 1, `KEY_CLR` = 2, `KEY_SPD` = 3;
  - the default `COLS`/`ROWS` values.
- Sub-module `key_edge`: a 4-bit synchronizer plus falling-edge detector, instantiated once.

## Test plan
- Reset: after `reset` is held 2 cycles, all outputs are at their reset values. No `sweep_valid` occurs over 10 `vblank_start` pulses while paused.
- Step press (Key[1] low for 5 cycles), `sweep_ready` = 1:
  - exactly 768 beats, (0,0) through (31,23), `sweep_clr` = 0;
  - `buf_sel` toggles 0 → 1 on the next `vblank_start` after `eng_idle`;
  - `gen_count` = 1.
- Run with `speed` = 0: sweeps start on every 8th `vblank_start`. After 3 speed presses, sweeps start on every `vblank_start` not consumed by SWAP.
- Backpressure: random `sweep_ready` (50%). Coordinates hold while ready is low, no beat is skipped or duplicated, and the total is still 768.
- Clear pressed mid-step-sweep: the current sweep completes and swaps, then a `sweep_clr` = 1 sweep runs and swaps. `gen_count` ends at 0.
- Same-cycle clear+step while paused: only the clear sweep runs.
- Reset asserted at beat 300: `sweep_valid` = 0 and `buf_sel` = 0 next cycle.

Source files
------------

// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types and constants for the Game of Life sequencer
package gol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_SWAP
  } gol_state_t;

  localparam int KEY_RUN  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_CLR  = 2;
  localparam int KEY_SPD  = 3;

  localparam int GOL_COLS = 32;
  localparam int GOL_ROWS = 24;

  // Last frame_cnt value of a generation period: (8 >> speed) - 1.
  function automatic logic [2:0] frame_last(input logic [1:0] spd);
    logic [3:0] fpg;
    fpg = 4'd8 >> spd;
    return 3'(fpg - 4'd1);
  endfunction

endpackage

// File: rtl/gol_sequencer_if.sv
// rtl/gol_sequencer_if.sv - sweep handshake between the sequencer and the cell engine
interface gol_sequencer_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          sweep_valid;
  logic          sweep_ready;
  logic [XW-1:0] sweep_x;
  logic [YW-1:0] sweep_y;
  logic          sweep_clr;
  logic          eng_idle;

  modport master (
    output sweep_valid, sweep_x, sweep_y, sweep_clr,
    input  sweep_ready, eng_idle
  );

  modport slave (
    input  sweep_valid, sweep_x, sweep_y, sweep_clr,
    output sweep_ready, eng_idle
  );
endinterface

// File: rtl/gol_sequencer_key_edge.sv
// rtl/gol_sequencer_key_edge.sv - key synchronizer and press (falling-edge) detector
module key_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output logic [3:0] fall
);
  logic [3:0] sync1, sync2, prev;

  // Keys are active-low, so released (all ones) is the safe reset level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      fall  <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
      fall  <= prev & ~sync2;
    end
  end
endmodule

// File: rtl/gol_sequencer.sv
// rtl/gol_sequencer.sv - key decode, generation scheduling and vblank buffer swap
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int COLS = GOL_COLS,
  parameter int ROWS = GOL_ROWS,
  parameter int XW   = 5,
  parameter int YW   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Key,
  input  logic                   vblank_start,
  gol_sequencer_if.master        sweep,
  output logic                   buf_sel,
  output logic                   running,
  output logic [1:0]             speed,
  output logic [15:0]            gen_count
);
  logic [3:0]    key_ev;
  gol_state_t    state, state_n;
  logic [2:0]    frame_cnt, frame_cnt_n;
  logic          clr_pend, clr_pend_n, step_pend, step_pend_n;
  logic          running_n, buf_sel_n;
  logic [1:0]    speed_n;
  logic [15:0]   gen_count_n;
  logic          valid_n, clr_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic          clr_ev, step_ev, xfer, last_x, last_y;
  logic          start, start_clr;

  key_edge u_key_edge (
    .clk   (clk),
    .reset (reset),
    .key   (Key),
    .fall  (key_ev)
  );

  // A same-cycle clear drops the step; steps are ignored while free-running.
  assign clr_ev  = key_ev[KEY_CLR];
  assign step_ev = key_ev[KEY_STEP] & ~running & ~clr_ev;
  assign xfer    = sweep.sweep_valid & sweep.sweep_ready;
  assign last_x  = (sweep.sweep_x == XW'(COLS - 1));
  assign last_y  = (sweep.sweep_y == YW'(ROWS - 1));

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    clr_pend_n  = clr_pend | clr_ev;
    step_pend_n = step_pend | step_ev;
    running_n   = running ^ key_ev[KEY_RUN];
    speed_n     = speed + {1'b0, key_ev[KEY_SPD]};
    gen_count_n = gen_count;
    buf_sel_n   = buf_sel;
    valid_n     = sweep.sweep_valid;
    clr_n       = sweep.sweep_clr;
    x_n         = sweep.sweep_x;
    y_n         = sweep.sweep_y;
    start       = 1'b0;
    start_clr   = 1'b0;

    case (state)
      ST_IDLE: begin
        // Events seen in IDLE start the sweep directly instead of via the pend flag.
        if (clr_pend || clr_ev) begin
          start      = 1'b1;
          start_clr  = 1'b1;
          clr_pend_n = 1'b0;
        end else if (step_pend || step_ev) begin
          start       = 1'b1;
          step_pend_n = 1'b0;
        end else if (running && vblank_start) begin
          if (frame_cnt >= frame_last(speed)) begin
            frame_cnt_n = '0;
            start       = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt + 3'd1;
          end
        end
      end
      ST_SWEEP: begin
        if (xfer) begin
          if (last_x) begin
            x_n = '0;
            if (last_y) begin
              y_n     = '0;
              valid_n = 1'b0;
              state_n = ST_DRAIN;
            end else begin
              y_n = sweep.sweep_y + YW'(1);
            end
          end else begin
            x_n = sweep.sweep_x + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (sweep.eng_idle) state_n = ST_SWAP;
      end
      ST_SWAP: begin
        if (vblank_start) begin
          buf_sel_n   = ~buf_sel;
          gen_count_n = sweep.sweep_clr ? 16'd0 : gen_count + 16'd1;
          clr_n       = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (start) begin
      state_n = ST_SWEEP;
      valid_n = 1'b1;
      clr_n   = start_clr;
      x_n     = '0;
      y_n     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      frame_cnt         <= '0;
      clr_pend          <= 1'b0;
      step_pend         <= 1'b0;
      running           <= 1'b0;
      speed             <= '0;
      gen_count         <= '0;
      buf_sel           <= 1'b0;
      sweep.sweep_valid <= 1'b0;
      sweep.sweep_clr   <= 1'b0;
      sweep.sweep_x     <= '0;
      sweep.sweep_y     <= '0;
    end else begin
      state             <= state_n;
      frame_cnt         <= frame_cnt_n;
      clr_pend          <= clr_pend_n;
      step_pend         <= step_pend_n;
      running           <= running_n;
      speed             <= speed_n;
      gen_count         <= gen_count_n;
      buf_sel           <= buf_sel_n;
      sweep.sweep_valid <= valid_n;
      sweep.sweep_clr   <= clr_n;
      sweep.sweep_x     <= x_n;
      sweep.sweep_y     <= y_n;
    end
  end
endmodule
